multiclock: RTL and testbench

MULTICLOCK -- requirements
Module: multiclock

---
 rtl/multiclock.sv | 66 ++++++
 tb/tb_multiclock.sv | 133 +++++++++++++
 2 files changed

// File: rtl/multiclock.sv
// multiclock: single-clock block with a registered AND, an in3 delay line
// and an in1 event counter that pulses out3 on every wrap.
module multiclock #(
    parameter int DEPTH2 = 2,
    parameter int CNT_W  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in1,
    input  logic in2,
    input  logic in3,
    output logic out1,
    output logic out2,
    output logic out3
);

    logic [DEPTH2-1:0] dly;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_max;

    // cnt wraps on this edge when it sits at all-ones and in1 counts
    assign cnt_max = &cnt;

    // out1: in1 AND in2, one cycle of latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1 <= 1'b0;
        end else begin
            out1 <= in1 & in2;
        end
    end

    // in3 delay line: free-running shift, stage 0 takes in3
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly <= '0;
        end else begin
            dly[0] <= in3;
            for (int i = 1; i < DEPTH2; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    // out2 is the last delay stage itself, so it comes straight from a flop
    assign out2 = dly[DEPTH2-1];

    // event counter: count on in1, wrap modulo 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (in1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // out3: one-cycle pulse following the edge on which cnt wrapped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out3 <= 1'b0;
        end else begin
            out3 <= in1 & cnt_max;
        end
    end

endmodule

// File: tb/tb_multiclock.sv
// tb_multiclock: directed vector table plus hand-written sequences
// for counter wrap, alternating counts and asynchronous reset.
module tb_multiclock;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in1 = 1'b0;
    logic in2 = 1'b0;
    logic in3 = 1'b0;
    logic out1, out2, out3;

    int n_tests = 0;
    int n_fail  = 0;

    multiclock #(.DEPTH2(2), .CNT_W(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .in1  (in1),
        .in2  (in2),
        .in3  (in3),
        .out1 (out1),
        .out2 (out2),
        .out3 (out3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic a, b, c;
        logic e1, e2, e3;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // drive at the falling edge, sample 1 time unit after the rising edge
    task automatic cyc(input logic r, input logic a, input logic b, input logic c);
        @(negedge clk);
        rst_n = r;
        in1 = a;
        in2 = b;
        in3 = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        check({name, "_out1"}, out1, 1'b0);
        check({name, "_out2"}, out2, 1'b0);
        check({name, "_out3"}, out3, 1'b0);
    endtask

    initial begin
        // in1,in2,in3 -> out1,out2,out3 after that edge; cnt starts at 0,
        // delay line at 00 right after reset release
        tbl[0] = '{1, 1, 1, 1, 0, 0};
        tbl[1] = '{1, 0, 0, 0, 1, 0};
        tbl[2] = '{0, 1, 1, 0, 0, 0};
        tbl[3] = '{0, 0, 1, 0, 1, 0};
        tbl[4] = '{0, 1, 0, 0, 1, 0};
        tbl[5] = '{1, 1, 0, 1, 0, 0};
        tbl[6] = '{0, 0, 0, 0, 0, 0};
        tbl[7] = '{1, 1, 1, 1, 0, 0};
        tbl[8] = '{0, 1, 1, 0, 1, 0};
        tbl[9] = '{1, 1, 0, 1, 1, 0};

        // reset held with random inputs
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
            check_zero($sformatf("rst_hold%0d", k));
        end

        // table: row 0 is applied on the release edge
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, tbl[k].a, tbl[k].b, tbl[k].c);
            check($sformatf("vec%0d_out1", k), out1, tbl[k].e1);
            check($sformatf("vec%0d_out2", k), out2, tbl[k].e2);
            check($sformatf("vec%0d_out3", k), out3, tbl[k].e3);
        end

        // held in1: pulses after edges 16 and 32 only
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            check($sformatf("hold_e%0d_out3", k), out3, (k == 16 || k == 32));
        end

        // alternating in1: 15 counts in 30 edges, no pulse yet
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            cyc(1'b1, 1'(k % 2), 1'b0, 1'b0);
            check($sformatf("alt_e%0d_out3", k), out3, 1'b0);
        end
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        check("alt_wrap_out3", out3, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        check("alt_after_out3", out3, 1'b0);

        // asynchronous reset mid-operation at cnt = 9, out2 = 1
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b1);
        end
        check("pre_async_out1", out1, 1'b1);
        check("pre_async_out2", out2, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("async");
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            check($sformatf("restart_e%0d_out3", k), out3, (k == 16));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
